// File: rtl/uart_tx_fifo_if.sv
// Bus between the transmit FIFO and its surroundings: the host push port plus
// the pacing handshake shared with uart_tx.
interface uart_tx_fifo_if #(
    parameter int p_WORD_LEN = 8,
    parameter int p_ADDR_W   = 4
);
    // Host push side
    logic                  i_wr_en;
    logic [p_WORD_LEN-1:0] i_wr_data;
    logic                  o_full;
    logic                  o_empty;
    logic [p_ADDR_W:0]     o_count;
    logic                  o_overflow;

    // uart_tx side
    logic                  i_tx_active;
    logic                  i_tx_done;
    logic                  o_send;
    logic [p_WORD_LEN-1:0] o_data;

    // The FIFO itself
    modport slave (
        input  i_wr_en, i_wr_data, i_tx_active, i_tx_done,
        output o_full, o_empty, o_count, o_overflow, o_send, o_data
    );

    // Host logic plus uart_tx, seen as a single environment
    modport master (
        output i_wr_en, i_wr_data, i_tx_active, i_tx_done,
        input  o_full, o_empty, o_count, o_overflow, o_send, o_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding uart_tx. Words pushed by the host are drained
// in order, one o_send pulse per word, paced by uart_tx o_active / o_done.
// All outputs are registered; reset is asynchronous and active-high.
module uart_tx_fifo #(
    parameter int p_WORD_LEN = 8,
    parameter int p_DEPTH    = 16,
    parameter int p_ADDR_W   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    localparam logic [p_ADDR_W:0] c_DEPTH = (p_ADDR_W + 1)'(p_DEPTH);

    state_t                state;
    logic [p_WORD_LEN-1:0] mem [p_DEPTH];
    logic [p_ADDR_W-1:0]   wr_ptr;
    logic [p_ADDR_W-1:0]   rd_ptr;
    logic [p_ADDR_W:0]     count;
    logic [p_ADDR_W:0]     count_next;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  send;
    logic [p_WORD_LEN-1:0] data;
    logic                  push;
    logic                  pop;

    // Decide this cycle's push/pop from registered flags and derive the next occupancy.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        push       = bus.i_wr_en && !full;
        pop        = (state == IDLE) && !empty && !bus.i_tx_active;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; the pointers alone define which
    // entries are valid, which keeps the storage mappable onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    // Pointers, occupancy and status flags; flags follow the count they accompany.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: non-blocking assignments, so every register here sees pre-edge values.
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == c_DEPTH);
            empty <= (count_next == '0);
            // A push against a full FIFO is dropped; remember that until reset.
            if (bus.i_wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Launch FSM: pop the head word, pulse send for one cycle, wait for frame end.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            send  <= 1'b0;
            data  <= '0;
        end else begin
            send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= LAUNCH;
                        send  <= 1'b1;
                        data  <= mem[rd_ptr];
                    end
                end
                LAUNCH:  state <= BUSY;
                BUSY: begin
                    if (bus.i_tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
    assign bus.o_send     = send;
    assign bus.o_data     = data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. A small uart_tx stand-in answers each
// o_send with a fixed-length frame (o_active high, then a one-cycle o_done)
// and records the launched words; the main sequence pushes words and checks
// flags, timing and the order of launched words against hand-computed values.
module tb_uart_tx_fifo;
    localparam int W     = 8;
    localparam int D     = 16;
    localparam int A     = 4;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold_busy;
    logic       model_active;
    int         total = 0;
    int         bad   = 0;
    int         n_send = 0;
    logic [7:0] sent_q [$];

    uart_tx_fifo_if #(.p_WORD_LEN(W), .p_ADDR_W(A)) bus ();

    assign bus.i_tx_active = hold_busy | model_active;

    uart_tx_fifo #(
        .p_WORD_LEN(W),
        .p_DEPTH   (D),
        .p_ADDR_W  (A)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count every cycle in which o_send is high.
    always @(negedge clk) begin
        if (bus.o_send === 1'b1) n_send++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = d;
        @(negedge clk);
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic expect_sent(input string tag, input logic [7:0] exp);
        int n = 0;
        while (sent_q.size() == 0 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (sent_q.size() == 0) check({tag, "_timeout"}, sent_q.size(), 1);
        else                    check(tag, sent_q.pop_front(), exp);
    endtask

    // uart_tx stand-in: one frame per o_send, data must hold and no new send may appear.
    initial begin : tx_model
        logic [7:0] word;
        logic       hold_ok;
        model_active  = 1'b0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_send === 1'b1 && !rst) begin
                word    = bus.o_data;
                hold_ok = 1'b1;
                sent_q.push_back(word);
                model_active = 1'b1;
                for (int i = 0; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rst) hold_ok = 1'b0;
                    if (hold_ok) begin
                        check("data_hold", bus.o_data, word);
                        check("no_send_in_frame", bus.o_send, 0);
                    end
                end
                model_active  = 1'b0;
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int         base;
        int         n;
        logic [7:0] v;

        rst           = 1'b1;
        hold_busy     = 1'b0;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = '0;
        step(2);
        check("rst_empty",    bus.o_empty,    1);
        check("rst_full",     bus.o_full,     0);
        check("rst_count",    bus.o_count,    0);
        check("rst_overflow", bus.o_overflow, 0);
        check("rst_send",     bus.o_send,     0);
        check("rst_data",     bus.o_data,     0);
        rst = 1'b0;
        step(2);

        // Single word into an empty FIFO with the line idle.
        base = n_send;
        push_word(8'hEE);
        check("single_count_after_push", bus.o_count, 1);
        check("single_no_send_yet",      bus.o_send,  0);
        step(1);
        check("single_send_high",  bus.o_send,  1);
        check("single_data",       bus.o_data,  8'hEE);
        check("single_count_zero", bus.o_count, 0);
        check("single_empty",      bus.o_empty, 1);
        step(1);
        check("single_send_low", bus.o_send, 0);
        step(3 * FRAME);
        check("single_send_pulses", n_send - base, 1);
        expect_sent("single_word", 8'hEE);

        // Back-to-back pushes with the line idle: order and pacing.
        base = n_send;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        expect_sent("order_0", 8'h11);
        expect_sent("order_1", 8'h22);
        expect_sent("order_2", 8'h33);
        step(3 * FRAME);
        check("order_send_pulses", n_send - base, 3);
        check("order_empty",       bus.o_empty,   1);

        // Push on the same edge as a pop: count stays, pushed word drains last.
        hold_busy = 1'b1;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        check("simul_count_before", bus.o_count, 3);
        hold_busy     = 1'b0;
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = 8'hA4;
        step(1);
        bus.i_wr_en   = 1'b0;
        check("simul_count_same", bus.o_count, 3);
        check("simul_send",       bus.o_send,  1);
        check("simul_head",       bus.o_data,  8'hA1);
        expect_sent("simul_0", 8'hA1);
        expect_sent("simul_1", 8'hA2);
        expect_sent("simul_2", 8'hA3);
        expect_sent("simul_3", 8'hA4);
        step(3 * FRAME);
        check("simul_empty", bus.o_empty, 1);

        // Fill to full while the line is busy, then overflow by one.
        base      = n_send;
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(i));
        check("full_count",       bus.o_count,    16);
        check("full_flag",        bus.o_full,     1);
        check("full_no_overflow", bus.o_overflow, 0);
        push_word(8'h10);
        check("ovf_count", bus.o_count,    16);
        check("ovf_full",  bus.o_full,     1);
        check("ovf_flag",  bus.o_overflow, 1);
        hold_busy = 1'b0;
        for (int i = 0; i < 16; i++) expect_sent("drain", 8'(i));
        step(3 * FRAME);
        check("drain_no_extra_word", sent_q.size(),  0);
        check("drain_send_pulses",   n_send - base,  16);
        check("drain_empty",         bus.o_empty,    1);
        check("drain_ovf_sticky",    bus.o_overflow, 1);

        // Reset in the middle of a launch with a full FIFO and overflow set.
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(8'h20 + i));
        check("rst2_full_before", bus.o_full,     1);
        check("rst2_ovf_before",  bus.o_overflow, 1);
        base      = n_send;
        hold_busy = 1'b0;
        n = 0;
        while (bus.o_send !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
        check("rst2_launch_seen", bus.o_send, 1);
        #2 rst = 1'b1;
        #1;
        check("rst2_async_send",  bus.o_send,     0);
        check("rst2_async_empty", bus.o_empty,    1);
        check("rst2_async_count", bus.o_count,    0);
        check("rst2_async_ovf",   bus.o_overflow, 0);
        check("rst2_async_full",  bus.o_full,     0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst2_no_send_in_reset", bus.o_send, 0);
        end
        rst = 1'b0;
        step(3 * FRAME);
        check("rst2_send_pulses", n_send - base, 1);
        check("rst2_still_empty", bus.o_empty,   1);
        check("rst2_count",       bus.o_count,   0);
        expect_sent("rst2_inflight", 8'h20);

        // Pointer wrap: 40 words in groups of 5.
        base = n_send;
        for (int g = 0; g < 8; g++) begin
            hold_busy = 1'b1;
            for (int k = 0; k < 5; k++) begin
                v = 8'(8'h80 + g * 5 + k);
                push_word(v);
            end
            hold_busy = 1'b0;
            for (int k = 0; k < 5; k++) begin
                v = 8'(8'h80 + g * 5 + k);
                expect_sent("wrap", v);
            end
        end
        step(3 * FRAME);
        check("wrap_send_pulses", n_send - base,  40);
        check("wrap_empty",       bus.o_empty,    1);
        check("wrap_count",       bus.o_count,    0);
        check("wrap_no_overflow", bus.o_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
